// File: rtl/mac_pe_acc.sv
// Systolic-array processing element: signed fixed-point MAC with a 2-stage pipeline,
// per-dot-product framing, round-half-up output conversion, saturation and flush.
module mac_pe_acc #(
  parameter int WORD_SIZE = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_SIZE  = 40
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic                 flush,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  output logic [WORD_SIZE-1:0] a_fwd,
  output logic [WORD_SIZE-1:0] b_fwd,
  output logic                 fwd_valid,
  output logic                 fwd_last,
  output logic [WORD_SIZE-1:0] out,
  output logic                 out_valid,
  output logic                 out_sat
);

  localparam int PW = 2 * WORD_SIZE;
  localparam int HW = ACC_SIZE - WORD_SIZE + 2;
  localparam logic signed [ACC_SIZE:0] HALF = (ACC_SIZE + 1)'(1) <<< (FRAC_BITS - 1);

  logic signed [PW-1:0]       p_r;
  logic                       v1;
  logic                       l1;
  logic signed [ACC_SIZE-1:0] acc;
  logic                       first;
  logic                       sticky;

  logic signed [ACC_SIZE-1:0] base;
  logic signed [ACC_SIZE:0]   sum_w;
  logic signed [ACC_SIZE-1:0] sum_c;
  logic                       acc_clamp;
  logic signed [ACC_SIZE:0]   rnd;
  logic signed [ACC_SIZE:0]   shf;
  logic [HW-1:0]              shf_hi;
  logic                       conv_clamp;
  logic [WORD_SIZE-1:0]       conv_val;

  // Accumulate at one guard bit above ACC_SIZE so overflow is visible before clamping.
  always_comb begin
    base      = first ? '0 : acc;
    sum_w     = $signed({base[ACC_SIZE-1], base})
              + $signed({{(ACC_SIZE + 1 - PW){p_r[PW-1]}}, p_r});
    acc_clamp = sum_w[ACC_SIZE] != sum_w[ACC_SIZE-1];
    if (acc_clamp)
      sum_c = sum_w[ACC_SIZE] ? {1'b1, {(ACC_SIZE-1){1'b0}}} : {1'b0, {(ACC_SIZE-1){1'b1}}};
    else
      sum_c = sum_w[ACC_SIZE-1:0];
  end

  always_comb begin
    rnd        = $signed({sum_c[ACC_SIZE-1], sum_c}) + HALF;
    shf        = rnd >>> FRAC_BITS;
    shf_hi     = shf[ACC_SIZE:WORD_SIZE-1];
    conv_clamp = !((&shf_hi) || !(|shf_hi));
    if (conv_clamp)
      conv_val = shf[ACC_SIZE] ? {1'b1, {(WORD_SIZE-1){1'b0}}} : {1'b0, {(WORD_SIZE-1){1'b1}}};
    else
      conv_val = shf[WORD_SIZE-1:0];
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      a_fwd     <= '0;
      b_fwd     <= '0;
      fwd_valid <= 1'b0;
      fwd_last  <= 1'b0;
    end else begin
      a_fwd     <= a;
      b_fwd     <= b;
      fwd_valid <= in_valid;
      fwd_last  <= in_valid & in_last;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      p_r <= '0;
      v1  <= 1'b0;
      l1  <= 1'b0;
    end else begin
      p_r <= $signed(a) * $signed(b);
      v1  <= in_valid & ~flush;
      l1  <= in_valid & in_last & ~flush;
    end
  end

  // A final term already in stage 1 still emits its result on a flush edge;
  // the flush then wins over any partial-sum update.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      acc       <= '0;
      first     <= 1'b1;
      sticky    <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (v1) begin
        if (l1) begin
          out       <= conv_val;
          out_valid <= 1'b1;
          out_sat   <= sticky | acc_clamp | conv_clamp;
          acc       <= '0;
          first     <= 1'b1;
          sticky    <= 1'b0;
        end else begin
          acc    <= sum_c;
          first  <= 1'b0;
          sticky <= sticky | acc_clamp;
        end
      end
      if (flush) begin
        acc    <= '0;
        first  <= 1'b1;
        sticky <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mac_pe_acc.md
Name: mac_pe_acc

Overview:
- Next-generation systolic-array processing element: signed fixed-point multiply-accumulate with a 2-stage pipeline, valid qualification and wide guard-bit accumulator.
- Adds per-dot-product framing (last marker, result strobe), round-half-up output conversion, saturation with sticky flag, and synchronous flush.
- Sits in each array cell; forwards operands east/south to neighbours exactly as the current PE does.

Parameters:
- WORD_SIZE, 16, operand and result width (signed two's complement).
- FRAC_BITS, 8, fractional bits of operands and result (Q format); 1 <= FRAC_BITS < WORD_SIZE.
- ACC_SIZE, 40, accumulator width; holds 2*FRAC_BITS fractional bits; must be >= 2*WORD_SIZE.

Ports:
- clk  input  1  clock, all state on rising edge.
- clear  input  1  reset, asynchronous, active-high.
- in_valid  input  1  a/b/in_last carry a valid term this cycle.
- in_last  input  1  this term is the final term of the current dot product; ignored when in_valid=0.
- flush  input  1  synchronous discard of pipeline and partial sum.
- a  input  WORD_SIZE  operand A.
- b  input  WORD_SIZE  operand B.
- a_fwd  output  WORD_SIZE  registered a to neighbour.
- b_fwd  output  WORD_SIZE  registered b to neighbour.
- fwd_valid  output  1  registered in_valid to neighbour.
- fwd_last  output  1  registered (in_valid & in_last) to neighbour.
- out  output  WORD_SIZE  rounded, saturated dot-product result.
- out_valid  output  1  one-cycle strobe: out is a new result.
- out_sat  output  1  saturation occurred in the dot product just presented; valid with out_valid.

Behaviour:
- Reset (clear=1, any time, async): every output 0; product/valid/last pipeline registers 0; accumulator 0; sticky flag 0; "first term" flag 1. In-flight terms lost.
- Forwarding: a_fwd, b_fwd, fwd_valid, fwd_last load inputs every edge, latency 1; unaffected by flush; data forwarded regardless of in_valid.
- Stage 1 (edge N): p_r <= full 2*WORD_SIZE signed product a*b (exact, no truncation); v1 <= in_valid & ~flush; l1 <= in_valid & in_last & ~flush.
- Stage 2 (edge N+1), when v1=1:
  - base = 0 if first flag set, else acc.
  - sum = base + sign-extended p_r at ACC_SIZE+1 bits; clamp to ACC_SIZE signed range; clamp sets sticky.
  - l1=0: acc <= clamped sum, first <= 0.
  - l1=1: out <= conv(clamped sum), out_valid <= 1, out_sat <= sticky | clamp | conv clamp; acc <= 0, first <= 1, sticky <= 0.
- v1=0: acc, first, sticky hold; out holds; out_valid <= 0.
- Latency: term with in_last at edge N -> out_valid high for the cycle after edge N+1 (2 cycles); exactly one cycle wide.
- conv(x): add 2^(FRAC_BITS-1) (round half toward +inf), arithmetic shift right FRAC_BITS, clamp to [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1].
- Bubbles: in_valid may drop any cycle; partial sum persists across bubbles indefinitely.
- Back-to-back frames: term after a last term starts a fresh sum with no dead cycle; full throughput 1 term/cycle.
- Single-term frame (in_valid & in_last on the first term) legal: result = conv(product).
- flush at edge N: v1, l1 <= 0 (term presented that cycle dropped); a term already in stage 1 still completes at edge N only if flush was not high when it entered; acc <= 0, first <= 1, sticky <= 0 at edge N; no out_valid produced for the discarded frame; out holds its last value.
- flush and clear together: clear dominates.

Test Plan:
- Reset: assert clear mid-frame after 2 terms -> all outputs 0 immediately; next frame a=0x0180,b=0x0200,last -> out=0x0300, out_sat=0, no carry-over.
- Dot product: terms (0x0100,0x0200),(0x0180,0x0200),(0xFF00,0x0280,last) with one bubble between terms 2 and 3 -> single out_valid, out=0x0280 (2+3-2.5=2.5); fwd_* track inputs at 1-cycle delay.
- Saturation: 4 terms a=b=0x7FFF, last on 4th -> out=0x7FFF, out_sat=1; following frame 0x0100*0x0100 -> out=0x0100, out_sat=0.
- Rounding: a=0x0001,b=0x0080,last -> out=0x0001; a=0x0001,b=0x007F -> 0x0000; a=0xFFFF,b=0x0080 -> 0x0000.
- Back-to-back: three single-term frames on consecutive cycles (0x0100*0x0100, 0x0200*0x0100, 0xFF00*0x0100) -> out_valid high 3 consecutive cycles, out=0x0100,0x0200,0xFF00.
- Flush: 2 terms, flush coincident with 3rd term, then term 0x0100*0x0300,last -> only one out_valid, out=0x0300.
